chunked_seq_adder: RTL

Multi-cycle, parametrised binary adder/subtractor built from a CHUNK-bit ripple slice that is reused over WIDTH/CHUNK clock cycles, LSB chunk first, with the carry held in a register between cycles. It is the sequential, wide-operand successor to the team's single-bit combinational adder cell. It serves datapaths where area matters more than latency. A start/busy/done handshake lets a controller FSM issue one operation at a time.

---
 rtl/adder_pkg.sv | 9 +
 rtl/chunk_ripple_adder.sv | 20 ++
 rtl/chunked_seq_adder.sv | 111 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding, counter sizing and operation codes for the chunked adder
package adder_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam logic SUB_ADD = 1'b0;
  localparam logic SUB_SUB = 1'b1;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunk_ripple_adder.sv
// chunk_ripple_adder: combinational CHUNK-bit ripple of full-adder cells, exposing the MSB carry-in
module chunk_ripple_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: WIDTH-bit add/subtract computed CHUNK bits per cycle, LSB chunk first
module chunked_seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = cnt_w(NCHUNK);
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK");
  end
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NCHUNK-1:0][CHUNK-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, sub_q, sub_d;
  logic busy_q, busy_d, done_q, done_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic [CHUNK-1:0] s_slice;
  logic co_slice, cm_slice, last;
  chunk_ripple_adder #(.CHUNK(CHUNK)) u_slice (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .s    (s_slice),
    .cout (co_slice),
    .c_msb(cm_slice)
  );
  assign last  = cnt_q == CW'(NCHUNK - 1);
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  // next-state: capture operands (b pre-inverted for subtract) in IDLE, write one slice per RUN cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE) begin
      if (start) begin
        a_d     = a;
        b_d     = (sub == SUB_SUB) ? ~b : b;
        carry_d = c_in ^ sub;
        sub_d   = sub;
        cnt_d   = '0;
        state_d = RUN;
        busy_d  = 1'b1;
      end
    end else begin
      sum_d[cnt_q] = s_slice;
      carry_d      = co_slice;
      cnt_d        = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        c_out_d = co_slice ^ sub_q;
        ovf_d   = cm_slice ^ co_slice;
      end
    end
  end
  // state and output registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
